// File: rtl/dual_pkg.sv
// Shared dual-rail types, bus FSM states and word-classification helpers for the
// N-user bus arbiter.
package dual_pkg;

  typedef struct packed {
    logic t;
    logic f;
  } dual_t;

  localparam dual_t DUAL_NULL = '{t: 1'b0, f: 1'b0};
  localparam dual_t DUAL_ZERO = '{t: 1'b0, f: 1'b1};
  localparam dual_t DUAL_ONE  = '{t: 1'b1, f: 1'b0};

  // Helpers take a word widened to MAX_DIGITS plus the count of live digits.
  localparam int MAX_DIGITS = 64;
  typedef dual_t [MAX_DIGITS-1:0] dword_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } bus_state_t;

  function automatic logic is_complete(input dword_t w, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && (w[i].t == w[i].f)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic is_nulled(input dword_t w, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && (w[i].t || w[i].f)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic has_illegal(input dword_t w, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && w[i].t && w[i].f) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational round-robin picker: first request found scanning upward from
// pointer+1 (wrapping), returned both one-hot and as an index.
module bus_rr_arbiter
  import dual_pkg::*;
#(
  parameter int USERS = 4,
  localparam int IW = (USERS > 1) ? $clog2(USERS) : 1
) (
  input  logic [USERS-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [USERS-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= USERS; k++) begin
      j = int'(ptr_i) + k;
      if (j >= USERS) j = j - USERS;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arb_n.sv
// N-user four-phase dual-rail bus arbiter with round-robin fairness and stability
// filtering. Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arb_n
  import dual_pkg::*;
#(
  parameter int USERS   = 4,
  parameter int INPUT   = 8,
  parameter int OUTPUT  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                                clk,
  input  logic                                reset,
  input  dual_t [USERS-1:0][INPUT-1:0]        user_input,
  output dual_t [USERS-1:0][OUTPUT-1:0]       user_output,
  output dual_t [INPUT-1:0]                   bus_input,
  input  dual_t [OUTPUT-1:0]                  bus_output,
  output logic  [USERS-1:0]                   grant,
  output logic                                busy,
  output logic                                illegal,
  output logic                                timeout
);

  localparam int IW = (USERS > 1) ? $clog2(USERS) : 1;

  function automatic dword_t widen_in(input dual_t [INPUT-1:0] w);
    dword_t r;
    r = '0;
    r[INPUT-1:0] = w;
    return r;
  endfunction

  function automatic dword_t widen_out(input dual_t [OUTPUT-1:0] w);
    dword_t r;
    r = '0;
    r[OUTPUT-1:0] = w;
    return r;
  endfunction

  bus_state_t                         state_q, state_d;
  logic [USERS-1:0]                   grant_q, grant_d;
  logic [IW-1:0]                      gidx_q, gidx_d;
  logic [IW-1:0]                      ptr_q, ptr_d;
  dual_t [INPUT-1:0]                  bin_q, bin_d;
  dual_t [USERS-1:0][OUTPUT-1:0]      uout_q, uout_d;
  logic                               illegal_q, illegal_d;
  dual_t [USERS-1:0][INPUT-1:0]       uin_prev_q;
  dual_t [OUTPUT-1:0]                 bout_prev_q;

  logic [USERS-1:0] u_cmp, u_nul;
  logic             b_cmp, b_nul, any_bad;
  logic [USERS-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             cnt_hit, fwd_to, drn_to;

  // A word counts only once it matches last cycle's sample and is fully settled.
  always_comb begin
    u_cmp   = '0;
    u_nul   = '0;
    any_bad = 1'b0;
    for (int i = 0; i < USERS; i++) begin
      u_cmp[i] = (user_input[i] == uin_prev_q[i]) && is_complete(widen_in(user_input[i]), INPUT);
      u_nul[i] = (user_input[i] == uin_prev_q[i]) && is_nulled(widen_in(user_input[i]), INPUT);
      any_bad  = any_bad | has_illegal(widen_in(user_input[i]), INPUT);
    end
    b_cmp   = (bus_output == bout_prev_q) && is_complete(widen_out(bus_output), OUTPUT);
    b_nul   = (bus_output == bout_prev_q) && is_nulled(widen_out(bus_output), OUTPUT);
    any_bad = any_bad | has_illegal(widen_out(bus_output), OUTPUT);
  end

  bus_rr_arbiter #(.USERS(USERS)) u_rr (
    .req_i (u_cmp),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign fwd_to = (state_q == FWD)   && !b_cmp && cnt_hit;
  assign drn_to = (state_q == DRAIN) && !b_nul && cnt_hit;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    bin_d     = bin_q;
    uout_d    = uout_q;
    illegal_d = illegal_q | any_bad;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          ptr_d   = arb_idx;
          bin_d   = user_input[arb_idx];
          state_d = FWD;
        end
      end
      FWD: begin
        if (b_cmp) begin
          uout_d[gidx_q] = bus_output;
          state_d        = HOLD;
        end else if (fwd_to) begin
          for (int d = 0; d < OUTPUT; d++) uout_d[gidx_q][d] = DUAL_ZERO;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Partial or still-complete words from the owner are deliberately ignored.
        if (u_nul[gidx_q]) begin
          bin_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (b_nul || drn_to) begin
          uout_d[gidx_q] = '0;
          grant_d        = '0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= IW'(USERS - 1);
      bin_q       <= '0;
      uout_q      <= '0;
      illegal_q   <= 1'b0;
      uin_prev_q  <= '0;
      bout_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      bin_q       <= bin_d;
      uout_q      <= uout_d;
      illegal_q   <= illegal_d;
      uin_prev_q  <= user_input;
      bout_prev_q <= bus_output;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  // Counts cycles spent in the current state; restarts on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (state_q == FWD || state_q == DRAIN) cnt_d = cnt_q + 1'b1;
  end

  assign cnt_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | fwd_to | drn_to;
    end
  end

  assign timeout = timeout_q;
`else
  assign cnt_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign user_output = uout_q;
  assign bus_input   = bin_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_bus_arb_n.sv
// Directed plus randomized bench for bus_arb_n; users and target are driven from a
// single sequence and checked against a round-robin reference model.
module tb_bus_arb_n;
  import dual_pkg::*;

  localparam int USERS  = 4;
  localparam int INPUT  = 8;
  localparam int OUTPUT = 8;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic                          clk = 1'b0;
  logic                          reset;
  dual_t [USERS-1:0][INPUT-1:0]  user_input;
  dual_t [USERS-1:0][OUTPUT-1:0] user_output;
  dual_t [INPUT-1:0]             bus_input;
  dual_t [OUTPUT-1:0]            bus_output;
  logic  [USERS-1:0]             grant;
  logic                          busy, illegal, timeout;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [USERS-1:0] pending;
  logic [7:0]       udata [USERS];
  int               last_g;

  always #5 clk = ~clk;

  bus_arb_n #(.USERS(USERS), .INPUT(INPUT), .OUTPUT(OUTPUT), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .user_input (user_input),
    .user_output(user_output),
    .bus_input  (bus_input),
    .bus_output (bus_output),
    .grant      (grant),
    .busy       (busy),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  function automatic logic [15:0] enc(input logic [7:0] v);
    logic [15:0] w;
    for (int i = 0; i < 8; i++) w[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return w;
  endfunction

  // Reference: the pending user at the smallest cyclic distance after the last winner.
  function automatic int rr_pick(input logic [USERS-1:0] pend, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = USERS + 1;
    for (int i = 0; i < USERS; i++) begin
      if (pend[i]) begin
        d = (i - last - 1 + 2 * USERS) % USERS;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int u, input logic [7:0] v);
    udata[u]      = v;
    user_input[u] = enc(v);
    pending[u]    = 1'b1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    user_input = '0;
    bus_output = '0;
    tick();
    tick();
    reset   = 1'b0;
    last_g  = USERS - 1;
    pending = '0;
  endtask

  task automatic add_random(input int g);
    for (int i = 0; i < USERS; i++) begin
      if (i != g && !pending[i] && $urandom_range(0, 1) == 1) present(i, 8'($urandom));
    end
  endtask

  // One complete four-phase transfer for whichever user the model expects next.
  task automatic serve(input logic [7:0] resp, input bit add_new, input bit bad,
                       output logic [USERS-1:0] gobs);
    int g, n;
    dual_t [USERS-1:0][OUTPUT-1:0] exp_o;
    logic [15:0] w;
    g = rr_pick(pending, last_g);
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    gobs = grant;
    chk("grant_rr", grant, 64'(1) << g);
    chk("bus_input_fwd", bus_input, enc(udata[g]));
    chk("busy_fwd", busy, 1);
    last_g     = g;
    pending[g] = 1'b0;
    if (add_new) add_random(g);
    if (bad) begin
      w = enc(resp);
      w[7:6] = 2'b11;
      bus_output = w;
      for (int k = 0; k < 4; k++) tick();
      chk("illegal_set", illegal, 1);
      chk("stay_fwd_outputs", user_output, 0);
      chk("stay_fwd_grant", grant, 64'(1) << g);
    end
    bus_output = enc(resp);
    n = 0;
    while (user_output[g] == '0 && n < 20) begin tick(); n++; end
    exp_o    = '0;
    exp_o[g] = enc(resp);
    chk("user_output_resp", user_output, exp_o);
    user_input[g] = '0;
    n = 0;
    while (bus_input != '0 && n < 20) begin tick(); n++; end
    chk("bus_input_null", bus_input, 0);
    bus_output = '0;
    n = 0;
    while (grant != '0 && n < 20) begin tick(); n++; end
    chk("grant_release", grant, 0);
    chk("user_output_null", user_output, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [USERS-1:0] gobs;
    logic [15:0]      w;
    int               n;
    int               order [6] = '{0, 1, 3, 0, 1, 3};

    // Reset state
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_bus_input", bus_input, 0);
    chk("rst_user_output", user_output, 0);

    // Single transfer with exact latencies
    present(1, 8'h5A);
    tick();
    chk("t2_grant_c1", grant, 0);
    chk("t2_bus_c1", bus_input, 0);
    tick();
    chk("t2_grant_c2", grant, 4'b0010);
    chk("t2_bus_c2", bus_input, enc(8'h5A));
    chk("t2_busy", busy, 1);
    bus_output = enc(8'h5A);
    tick();
    chk("t2_uout_early", user_output, 0);
    tick();
    chk("t2_uout", user_output[1], enc(8'h5A));
    user_input[1] = '0;
    tick();
    tick();
    chk("t2_bus_null", bus_input, 0);
    bus_output = '0;
    tick();
    chk("t2_busy_drain", busy, 1);
    tick();
    chk("t2_grant_end", grant, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_uout_end", user_output, 0);
    last_g     = 1;
    pending[1] = 1'b0;

    // Unstable and partial words never raise a request
    for (int k = 0; k < 6; k++) begin
      user_input[0] = enc((k % 2 == 0) ? 8'h00 : 8'h01);
      tick();
      chk("t4_unstable", grant, 0);
    end
    w = enc(8'h0F);
    w[15:8] = 8'h00;
    user_input[0] = w;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_partial", grant, 0);
    end
    present(0, 8'h3C);
    tick();
    chk("t4_stable_c1", grant, 0);
    tick();
    chk("t4_stable_c2", grant, 4'b0001);
    serve(8'hA5, 1'b0, 1'b0, gobs);

    // Simultaneous requesters with re-requests follow round-robin order
    do_reset();
    present(0, 8'h11);
    present(1, 8'h22);
    present(3, 8'h44);
    for (int k = 0; k < 6; k++) begin
      serve(8'($urandom), 1'b0, 1'b0, gobs);
      chk("t3_order", gobs, 64'(1) << order[k]);
      present(order[k], 8'($urandom));
    end
    n = 0;
    while (pending != '0 && n < 8) begin
      serve(8'($urandom), 1'b0, 1'b0, gobs);
      n++;
    end

    // Asynchronous reset in the middle of a transfer
    present(2, 8'hC3);
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    chk("t1_grant2", grant, 4'b0100);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_grant", grant, 0);
    chk("t1_rst_bus", bus_input, 0);
    chk("t1_rst_uout", user_output, 0);
    chk("t1_rst_busy", busy, 0);
    present(0, 8'h77);
    last_g = USERS - 1;
    tick();
    tick();
    reset = 1'b0;
    serve(8'h12, 1'b0, 1'b0, gobs);
    chk("t1_first_user0", gobs, 4'b0001);
    serve(8'h34, 1'b0, 1'b0, gobs);
    chk("t1_then_user2", gobs, 4'b0100);

    // Illegal digit on the target response
    chk("t5_illegal_clear", illegal, 0);
    present(3, 8'h96);
    serve(8'h81, 1'b0, 1'b1, gobs);
    tick();
    chk("t5_illegal_sticky", illegal, 1);
    do_reset();
    chk("t5_illegal_reset", illegal, 0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      if (pending == '0) present(int'($urandom_range(0, USERS - 1)), 8'($urandom));
      serve(8'($urandom), 1'b1, 1'b0, gobs);
    end
    n = 0;
    while (pending != '0 && n < 8) begin
      serve(8'($urandom), 1'b0, 1'b0, gobs);
      n++;
    end

`ifdef BUS_TIMEOUT_EN
    // Silent then stuck target trips the watchdog in FWD and DRAIN
    do_reset();
    present(1, 8'h5A);
    n = 0;
    while (user_output[1] == '0 && n < 60) begin tick(); n++; end
    chk("t6_fwd_timeout_word", user_output[1], enc(8'h00));
    chk("t6_timeout_flag", timeout, 1);
    bus_output    = enc(8'h11);
    user_input[1] = '0;
    n = 0;
    while (grant != '0 && n < 80) begin tick(); n++; end
    chk("t6_drain_grant", grant, 0);
    chk("t6_drain_uout", user_output, 0);
    chk("t6_drain_busy", busy, 0);
    bus_output = '0;
`else
    chk("timeout_tied", timeout, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
